// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer: multicycle instruction sequencer with memory-wait timeout and trap handling
module multicycle_sequencer #(
    parameter int TIMEOUT = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    input  logic [3:0]  status,
    output logic [31:0] ir,
    output logic        mem_req,
    output logic        mem_we,
    output logic        reg_we,
    output logic        pc_en,
    output logic        pcsrc,
    output logic [2:0]  state,
    output logic        halted,
    output logic [1:0]  fault,
    output logic [31:0] instret
);
    localparam logic [2:0] FETCH = 3'd0, DECODE = 3'd1, EXEC = 3'd2, MEM = 3'd3, WB = 3'd4, TRAP = 3'd5;
    localparam logic [6:0] OP_NOP = 7'b0000000, OP_R = 7'b0110011, OP_I = 7'b0010011,
                           OP_LD = 7'b0000011, OP_ST = 7'b0100011, OP_BR = 7'b1100011;
    logic [2:0] nxt;
    logic [1:0] nfault;
    logic [7:0] wcnt;
    logic [6:0] op;
    logic       expired;
    logic       unused_status;
    assign op = ir[6:0];
    assign expired = !mem_ready && wcnt == 8'(TIMEOUT - 1);
    assign unused_status = ^{status[3], status[1:0]};
    // Strobes are forced low while reset is asserted so an abandoned instruction has no side effects
    assign mem_req = !reset && (state == FETCH || state == MEM);
    assign mem_we  = !reset && state == MEM && op == OP_ST;
    assign reg_we  = !reset && state == WB;
    assign pc_en   = !reset && ((state == DECODE && op == OP_NOP) || (state == EXEC && op == OP_BR) ||
                                (state == MEM && op == OP_ST && mem_ready) || state == WB);
    assign pcsrc   = !reset && state == EXEC && op == OP_BR && status[2];
    assign halted  = !reset && state == TRAP;
    always_comb begin
        nxt = state;
        nfault = fault;
        case (state)
            FETCH: begin
                if (mem_ready) nxt = DECODE;
                else if (expired) begin
                    nxt = TRAP;
                    nfault = 2'b10;
                end
            end
            DECODE: begin
                if (op == OP_NOP) nxt = FETCH;
                else if (op inside {OP_R, OP_I, OP_LD, OP_ST, OP_BR}) nxt = EXEC;
                else begin
                    nxt = TRAP;
                    nfault = 2'b01;
                end
            end
            EXEC: nxt = (op == OP_R || op == OP_I) ? WB : (op == OP_LD || op == OP_ST) ? MEM : FETCH;
            MEM: begin
                if (mem_ready) nxt = (op == OP_LD) ? WB : FETCH;
                else if (expired) begin
                    nxt = TRAP;
                    nfault = 2'b11;
                end
            end
            WB: nxt = FETCH;
            TRAP: nxt = TRAP;
            default: begin
                nxt = TRAP;
                nfault = 2'b01;
            end
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FETCH;
            ir <= '0;
            fault <= '0;
            instret <= '0;
            wcnt <= '0;
        end else begin
            state <= nxt;
            fault <= nfault;
            instret <= instret + 32'(pc_en);
            wcnt <= (nxt == state && (state == FETCH || state == MEM)) ? wcnt + 8'd1 : '0;
            if (state == FETCH && mem_ready) ir <= mem_rdata;
        end
    end
endmodule

// File: doc/multicycle_sequencer.md
MULTICYCLE_SEQUENCER -- requirements
Module: multicycle_sequencer

Interface
REQ-001 Parameter TIMEOUT, default 8: max cycles a FETCH or MEM state waits for mem_ready before trapping (legal range 2..255).
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 mem_rdata  input  32  instruction word from memory, valid when mem_ready=1 in FETCH.
REQ-005 mem_ready  input  1  memory completion strobe for the current mem_req.
REQ-006 status  input  4  ALU flags; status[2] = zero/branch-taken flag.
REQ-007 ir  output  32  latched instruction register, fed to control decode.
REQ-008 mem_req  output  1  memory access request (FETCH or MEM state).
REQ-009 mem_we  output  1  memory write strobe (store in MEM state only).
REQ-010 reg_we  output  1  register-file write enable, one-cycle pulse.
REQ-011 pc_en  output  1  PC update enable, one-cycle pulse per retired instruction.
REQ-012 pcsrc  output  1  PC source select: 0 = PC+4, 1 = branch target.
REQ-013 state  output  3  current state encoding.
REQ-014 halted  output  1  high while in TRAP.
REQ-015 fault  output  2  trap cause: 00 none, 01 illegal opcode, 10 fetch timeout, 11 memory timeout.
REQ-016 instret  output  32  count of retired instructions.

Function
REQ-017 States SHALL be FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5; codes 6-7 SHALL go to TRAP with fault=01.
REQ-018 Outputs mem_req, mem_we, reg_we, pc_en, pcsrc SHALL be Moore-style decodes of state plus latched ir/status as defined below; otherwise 0.
REQ-019 FETCH: mem_req=1; on mem_ready=1, ir <= mem_rdata, next DECODE; else stay.
REQ-020 DECODE on ir[6:0]: 0000000 -> pc_en=1, pcsrc=0, next FETCH (NOP); 0110011, 0010011, 0000011, 0100011, 1100011 -> EXEC; any other -> TRAP, fault=01.
REQ-021 EXEC: one cycle; R/I-ALU -> WB; load/store -> MEM; branch -> pc_en=1, pcsrc=status[2] sampled this cycle, next FETCH.
REQ-022 MEM: mem_req=1, mem_we=1 only for store (0100011); on mem_ready=1, load -> WB, store -> pc_en=1, pcsrc=0, next FETCH.
REQ-023 WB: reg_we=1, pc_en=1, pcsrc=0, next FETCH.
REQ-024 Latency with mem_ready=1 on first request cycle: NOP 2, branch 3, R/I 4, store 4, load 5 cycles.
REQ-025 Wait counter (8 bits) SHALL clear on entering FETCH or MEM and increment each cycle there with mem_ready=0.
REQ-026 If mem_ready=0 and counter==TIMEOUT-1: next TRAP, fault=10 from FETCH, 11 from MEM; mem_ready=1 on that same cycle completes normally.
REQ-027 TRAP: all strobes 0, halted=1, ir and fault held; exit only via reset.
REQ-028 instret SHALL increment by 1 on every cycle pc_en=1, wrapping 0xFFFFFFFF -> 0.
REQ-029 ir SHALL change only in FETCH on mem_ready=1.
REQ-030 mem_rdata and status SHALL be ignored outside FETCH and EXEC respectively.

Reset
REQ-031 reset=1 at a rising edge SHALL force state=FETCH, ir=0, fault=00, instret=0, wait counter=0, overriding every other event that cycle.
REQ-032 Reset mid-instruction (any state, including TRAP) SHALL abandon it with no pc_en, reg_we or mem_we asserted in the reset cycle.
REQ-033 During reset cycle outputs SHALL read mem_req=0, mem_we=0, reg_we=0, pc_en=0, pcsrc=0, halted=0.

Verification
REQ-034 R-type 0x007302B3 (add x5,x6,x7), mem_ready always 1 -> states 0,1,2,4; reg_we and pc_en high only in cycle 4; instret=1.
REQ-035 Load 0x00002083 with mem_ready delayed 3 cycles in MEM -> MEM held 4 cycles, then WB; total 8 cycles; mem_we=0 throughout.
REQ-036 Branch 0x00000063 with status=4'b0100 in EXEC -> pc_en=1, pcsrc=1 in EXEC; with status=0 -> pcsrc=0; reg_we never 1.
REQ-037 Opcode 0x7F fetched -> TRAP after DECODE, fault=01, halted=1, instret unchanged; reset -> FETCH, fault=00.
REQ-038 TIMEOUT=8, mem_ready held 0 in FETCH -> TRAP on 8th wait cycle, fault=10; repeat with mem_ready=1 on 8th cycle -> normal DECODE.
REQ-039 Store 0x00112023, reset asserted during MEM -> no mem_we at/after reset edge, state=FETCH, instret=0.
